// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing and 160x120x3 framebuffer constants for the pixel sink.
package vga_pkg;
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W    = 15;

    localparam int COLOR_W   = 3;
    typedef logic [COLOR_W-1:0] color_t;
endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: write port A, registered read port B (old data on collision).
module fb_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we_a,
    input  logic [AW-1:0] i_addr_a,
    input  color_t        i_din_a,
    input  logic          i_re_b,
    input  logic [AW-1:0] i_addr_b,
    output color_t        o_dout_b
);
    color_t r_mem [0:DEPTH-1];
    color_t r_dout;

    always_ff @(posedge clk) begin
        if (i_we_a) begin
            r_mem[i_addr_a] <= i_din_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (i_re_b) begin
            r_dout <= r_mem[i_addr_b];
        end
    end

    assign o_dout_b = r_dout;
endmodule

// File: rtl/pixel_sink_scanout.sv
// Plot-write sink into a 160x120x3 framebuffer, scanned out as 640x480@60 VGA with 4x4 replication.
// Build macro TILE_FB_CLEAR_EN adds a post-reset clear sweep of the framebuffer and the clear_busy port.
module pixel_sink_scanout #(
    parameter int FB_WIDTH   = 160,
    parameter int FB_HEIGHT  = 120,
    parameter int SCALE_LOG2 = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       plot,
    input  logic [7:0] VGA_X,
    input  logic [6:0] VGA_Y,
    input  logic [2:0] VGA_COLOR,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
`ifdef TILE_FB_CLEAR_EN
    ,
    output logic       clear_busy
`endif
);
    import vga_pkg::*;

    function automatic logic [ADDR_W-1:0] fb_addr(input logic [ADDR_W-1:0] row,
                                                  input logic [ADDR_W-1:0] col);
        return (row << 7) + (row << 5) + col;
    endfunction

    function automatic logic [7:0] expand_bit(input logic b);
        return b ? 8'hFF : 8'h00;
    endfunction

    logic              r_vga_clk;
    logic              w_pix_en;
    logic [9:0]        r_hcount;
    logic [9:0]        r_vcount;

    assign w_pix_en = ~r_vga_clk;

    // S0: scan counters
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_vga_clk <= 1'b0;
            r_hcount  <= '0;
            r_vcount  <= '0;
        end else begin
            r_vga_clk <= ~r_vga_clk;
            if (w_pix_en) begin
                if (r_hcount == 10'(H_TOTAL - 1)) begin
                    r_hcount <= '0;
                    r_vcount <= (r_vcount == 10'(V_TOTAL - 1)) ? '0 : r_vcount + 10'd1;
                end else begin
                    r_hcount <= r_hcount + 10'd1;
                end
            end
        end
    end

    logic              w_vis_p0;
    logic              w_hsync_p0;
    logic              w_vsync_p0;
    logic [ADDR_W-1:0] w_rd_addr_p0;

    assign w_vis_p0     = (r_hcount < 10'(H_VISIBLE)) && (r_vcount < 10'(V_VISIBLE));
    assign w_hsync_p0   = (r_hcount >= 10'(H_VISIBLE + H_FP)) &&
                          (r_hcount <  10'(H_VISIBLE + H_FP + H_SYNC));
    assign w_vsync_p0   = (r_vcount >= 10'(V_VISIBLE + V_FP)) &&
                          (r_vcount <  10'(V_VISIBLE + V_FP + V_SYNC));
    assign w_rd_addr_p0 = fb_addr(ADDR_W'(r_vcount >> SCALE_LOG2), ADDR_W'(r_hcount >> SCALE_LOG2));

    logic              w_plot_we;
    logic [ADDR_W-1:0] w_plot_addr;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    color_t            w_wdata;

    // Out-of-range coordinates are dropped rather than aliased onto another row.
    assign w_plot_we   = plot && (int'(VGA_X) < FB_WIDTH) && (int'(VGA_Y) < FB_HEIGHT);
    assign w_plot_addr = fb_addr(ADDR_W'(VGA_Y), ADDR_W'(VGA_X));

`ifdef TILE_FB_CLEAR_EN
    logic              r_clr_busy;
    logic [ADDR_W-1:0] r_clr_addr;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_clr_busy <= 1'b1;
            r_clr_addr <= '0;
        end else if (r_clr_busy) begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
            if (r_clr_addr == ADDR_W'(FB_DEPTH - 1)) begin
                r_clr_busy <= 1'b0;
            end
        end
    end

    assign clear_busy = r_clr_busy | reset;
    assign w_we       = ~reset & (r_clr_busy | w_plot_we);
    assign w_waddr    = r_clr_busy ? r_clr_addr : w_plot_addr;
    assign w_wdata    = r_clr_busy ? color_t'(0) : VGA_COLOR;
`else
    assign w_we       = w_plot_we;
    assign w_waddr    = w_plot_addr;
    assign w_wdata    = VGA_COLOR;
`endif

    logic [ADDR_W-1:0] r_rd_addr_p1;
    logic              r_hsync_p1, r_vsync_p1, r_vis_p1;
    logic              r_hsync_p2, r_vsync_p2, r_vis_p2;
    color_t            w_rd_data_p2;
    logic [7:0]        r_r_p3, r_g_p3, r_b_p3;
    logic              r_hs_n_p3, r_vs_n_p3, r_blank_n_p3;

    // S2: synchronous RAM read
    fb_ram #(
        .DEPTH (FB_DEPTH),
        .AW    (ADDR_W)
    ) u_ram (
        .clk      (CLOCK_50),
        .rst      (reset),
        .i_we_a   (w_we),
        .i_addr_a (w_waddr),
        .i_din_a  (w_wdata),
        .i_re_b   (w_pix_en),
        .i_addr_b (r_rd_addr_p1),
        .o_dout_b (w_rd_data_p2)
    );

    // S1 address/control, S2 control delay, S3 output registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_rd_addr_p1 <= '0;
            r_hsync_p1   <= 1'b0;
            r_vsync_p1   <= 1'b0;
            r_vis_p1     <= 1'b0;
            r_hsync_p2   <= 1'b0;
            r_vsync_p2   <= 1'b0;
            r_vis_p2     <= 1'b0;
            r_r_p3       <= '0;
            r_g_p3       <= '0;
            r_b_p3       <= '0;
            r_hs_n_p3    <= 1'b1;
            r_vs_n_p3    <= 1'b1;
            r_blank_n_p3 <= 1'b0;
        end else if (w_pix_en) begin
            if (w_vis_p0) begin
                r_rd_addr_p1 <= w_rd_addr_p0;
            end
            r_hsync_p1   <= w_hsync_p0;
            r_vsync_p1   <= w_vsync_p0;
            r_vis_p1     <= w_vis_p0;
            r_hsync_p2   <= r_hsync_p1;
            r_vsync_p2   <= r_vsync_p1;
            r_vis_p2     <= r_vis_p1;
            r_r_p3       <= r_vis_p2 ? expand_bit(w_rd_data_p2[2]) : 8'h00;
            r_g_p3       <= r_vis_p2 ? expand_bit(w_rd_data_p2[1]) : 8'h00;
            r_b_p3       <= r_vis_p2 ? expand_bit(w_rd_data_p2[0]) : 8'h00;
            r_hs_n_p3    <= ~r_hsync_p2;
            r_vs_n_p3    <= ~r_vsync_p2;
            r_blank_n_p3 <= r_vis_p2;
        end
    end

    assign VGA_R       = r_r_p3;
    assign VGA_G       = r_g_p3;
    assign VGA_B       = r_b_p3;
    assign VGA_HS      = r_hs_n_p3;
    assign VGA_VS      = r_vs_n_p3;
    assign VGA_BLANK_N = r_blank_n_p3;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = r_vga_clk;
endmodule

// File: tb/tb_pixel_sink_scanout.sv
// Directed bench for pixel_sink_scanout: reset state, write path, scan timing and 4x4 replicated colour.
// With TILE_FB_CLEAR_EN defined it exercises the post-reset clear sweep instead of the scan-out image.
module tb_pixel_sink_scanout;
    logic       CLOCK_50;
    logic       reset;
    logic       plot;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] VGA_COLOR;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
`ifdef TILE_FB_CLEAR_EN
    logic       clear_busy;
`endif

    int errors = 0;
    int checks = 0;

    logic [2:0] fbm [0:119][0:159];

    pixel_sink_scanout dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .plot        (plot),
        .VGA_X       (VGA_X),
        .VGA_Y       (VGA_Y),
        .VGA_COLOR   (VGA_COLOR),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_CLK     (VGA_CLK)
`ifdef TILE_FB_CLEAR_EN
        ,
        .clear_busy  (clear_busy)
`endif
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_plot(input int x, input int y, input logic [2:0] c);
        plot      = 1'b1;
        VGA_X     = 8'(x);
        VGA_Y     = 7'(y);
        VGA_COLOR = c;
        if (x < 160 && y < 120) fbm[y][x] = c;
        @(posedge CLOCK_50); #1;
        plot = 1'b0;
    endtask

    function automatic logic [26:0] expected(input int h, input int v);
        logic       vis;
        logic [2:0] c;
        vis = (h < 640) && (v < 480);
        c   = vis ? fbm[v / 4][h / 4] : 3'b000;
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}},
                !((h >= 656) && (h < 752)), !((v >= 490) && (v < 492)), vis};
    endfunction

`ifdef TILE_FB_CLEAR_EN
    task automatic run_sweep(input bit inject, output int cnt);
        cnt = 0;
        while (clear_busy === 1'b1 && cnt < 20000) begin
            if (inject && cnt == 100) begin
                plot = 1'b1; VGA_X = 8'd5; VGA_Y = 7'd5; VGA_COLOR = 3'b111;
            end else begin
                plot = 1'b0;
            end
            cnt++;
            @(posedge CLOCK_50); #1;
        end
        plot = 1'b0;
    endtask
`endif

    initial begin
        int n, h, v, cnt;
        int hs_low, vs_low, blank_hi, line_bad, first_bad_h, clk_bad;
        logic [26:0] obs_vec;

        for (int r = 0; r < 120; r++)
            for (int c = 0; c < 160; c++)
                fbm[r][c] = 3'b000;

        reset = 1'b1; plot = 1'b0; VGA_X = '0; VGA_Y = '0; VGA_COLOR = '0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_R", VGA_R, 8'h00);
        check("rst_G", VGA_G, 8'h00);
        check("rst_B", VGA_B, 8'h00);
        check("rst_HS", VGA_HS, 1'b1);
        check("rst_VS", VGA_VS, 1'b1);
        check("rst_BLANK_N", VGA_BLANK_N, 1'b0);
        check("rst_VGA_CLK", VGA_CLK, 1'b0);
        check("SYNC_N", VGA_SYNC_N, 1'b0);

`ifdef TILE_FB_CLEAR_EN
        check("clear_busy_in_reset", clear_busy, 1'b1);
        reset = 1'b0;
        run_sweep(1'b1, cnt);
        check("sweep_len_first", cnt, 19200);
        check("plot_during_sweep_dropped", dut.u_ram.r_mem[805], 3'b000);

        do_plot(0, 0, 3'b111);
        do_plot(5, 5, 3'b111);
        do_plot(159, 119, 3'b111);
        do_plot(160, 5, 3'b111);
        do_plot(3, 120, 3'b111);
        check("fill_mem0", dut.u_ram.r_mem[0], 3'b111);
        check("fill_mem805", dut.u_ram.r_mem[805], 3'b111);
        check("fill_mem19199", dut.u_ram.r_mem[19199], 3'b111);
        check("x160_dropped", dut.u_ram.r_mem[960], 3'b000);
        check("y120_dropped", dut.u_ram.r_mem[3], 3'b000);

        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        check("clear_busy_reset_pulse", clear_busy, 1'b1);
        reset = 1'b0;
        run_sweep(1'b0, cnt);
        check("sweep_len_second", cnt, 19200);
        check("cleared_mem0", dut.u_ram.r_mem[0], 3'b000);
        check("cleared_mem805", dut.u_ram.r_mem[805], 3'b000);
        check("cleared_mem19199", dut.u_ram.r_mem[19199], 3'b000);
        check("clear_busy_after", clear_busy, 1'b0);
`else
        reset = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        do_plot(0, 0, 3'b100);
        do_plot(159, 119, 3'b011);
        do_plot(160, 5, 3'b111);
        do_plot(3, 120, 3'b111);
        do_plot(1, 2, 3'b001);
        for (int x = 10; x <= 44; x++) do_plot(x, 20, 3'b111);

        check("mem_0_0", dut.u_ram.r_mem[0], 3'b100);
        check("mem_159_119", dut.u_ram.r_mem[19199], 3'b011);
        check("x160_dropped", dut.u_ram.r_mem[960], 3'b000);
        check("y120_dropped", dut.u_ram.r_mem[3], 3'b000);
        check("burst_before", dut.u_ram.r_mem[3209], 3'b000);
        check("burst_after", dut.u_ram.r_mem[3245], 3'b000);
        for (int x = 10; x <= 44; x++)
            check($sformatf("burst_x%0d", x), dut.u_ram.r_mem[3200 + x], 3'b111);

        // Mid-frame reset: scan restarts at (0,0) with the written image intact.
        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        check("midrst_HS", VGA_HS, 1'b1);
        check("midrst_BLANK_N", VGA_BLANK_N, 1'b0);
        check("midrst_VGA_CLK", VGA_CLK, 1'b0);
        reset = 1'b0;

        hs_low = 0; vs_low = 0; blank_hi = 0; line_bad = 0; first_bad_h = 0; clk_bad = 0;
        for (int cyc = 1; cyc <= 19204; cyc++) begin
            @(posedge CLOCK_50); #1;
            if (VGA_CLK !== cyc[0]) clk_bad++;
            if (cyc >= 5 && cyc[0]) begin
                n = (cyc - 5) / 2;
                h = n % 800;
                v = n / 800;
                obs_vec = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N};
                if (obs_vec !== expected(h, v)) begin
                    if (line_bad == 0) first_bad_h = h;
                    line_bad++;
                end
                if (VGA_HS === 1'b0) hs_low++;
                if (VGA_VS === 1'b0) vs_low++;
                if (VGA_BLANK_N === 1'b1) blank_hi++;

                if (v == 0 && h == 0)   check("px_0_0_red", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
                if (v == 3 && h == 3)   check("px_3_3_red", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
                if (v == 0 && h == 4)   check("px_4_0_black", {VGA_R, VGA_G, VGA_B}, 24'h000000);
                if (v == 8 && h == 4)   check("px_4_8_blue", {VGA_R, VGA_G, VGA_B}, 24'h0000FF);
                if (v == 11 && h == 7)  check("px_7_11_blue", {VGA_R, VGA_G, VGA_B}, 24'h0000FF);
                if (v == 8 && h == 8)   check("px_8_8_black", {VGA_R, VGA_G, VGA_B}, 24'h000000);
                if (v == 8 && h == 3)   check("px_3_8_black", {VGA_R, VGA_G, VGA_B}, 24'h000000);
                if (v == 0 && h == 639) check("px_639_0_blank_n", VGA_BLANK_N, 1'b1);
                if (v == 0 && h == 640) check("px_640_0_blank_n", VGA_BLANK_N, 1'b0);
                if (v == 0 && h == 655) check("px_655_0_hs", VGA_HS, 1'b1);
                if (v == 0 && h == 656) check("px_656_0_hs", VGA_HS, 1'b0);
                if (v == 0 && h == 751) check("px_751_0_hs", VGA_HS, 1'b0);
                if (v == 0 && h == 752) check("px_752_0_hs", VGA_HS, 1'b1);

                if (h == 799) begin
                    check($sformatf("line%0d_pixels_first_bad_h%0d", v, first_bad_h), line_bad, 0);
                    check($sformatf("line%0d_hs_low", v), hs_low, 96);
                    check($sformatf("line%0d_vs_low", v), vs_low, 0);
                    check($sformatf("line%0d_blank_hi", v), blank_hi, 640);
                    hs_low = 0; vs_low = 0; blank_hi = 0; line_bad = 0; first_bad_h = 0;
                end
            end
        end
        check("vga_clk_phase", clk_bad, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
